// File: rtl/uart_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder_pkg
// Brief    : Shared command-byte layout, FSM encoding and parameter check
//            for the UART command decoder.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_decoder_pkg;

    localparam int CMD_START_BIT = 7;
    localparam int CMD_STOP_BIT  = 6;
    localparam int CMD_MODE_BIT  = 5;
    localparam int CMD_SEL_MSB   = 3;
    localparam int CMD_SEL_LSB   = 0;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_REPEAT  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT  = 2'd1,
        S_FREQ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // A packet is one command byte followed by two byte-aligned patterns.
    function automatic bit params_legal(input int data_bit, input int pack_num,
                                        input int num_ch, input int timeout_cyc);
        return (data_bit >= 8) && (data_bit % 8 == 0) &&
               (pack_num == 1 + 2 * (data_bit / 8)) &&
               (num_ch >= 1) && (num_ch <= 16) &&
               (timeout_cyc >= 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder_if
// Brief    : Byte-stream input and decoded-packet output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if #(
    parameter int DATA_BIT = 32
);
    logic [7:0]          i_data;
    logic                i_rx_done_tick;
    logic [DATA_BIT-1:0] o_output_pattern;
    logic [DATA_BIT-1:0] o_freq_pattern;
    logic [3:0]          o_sel_out;
    logic                o_start;
    logic                o_stop;
    logic                o_mode;
    logic                o_done_tick;
    logic                o_err_tick;

    // master: byte source / packet consumer side
    modport master (
        output i_data, i_rx_done_tick,
        input  o_output_pattern, o_freq_pattern, o_sel_out,
               o_start, o_stop, o_mode, o_done_tick, o_err_tick
    );

    // slave: the decoder itself
    modport slave (
        input  i_data, i_rx_done_tick,
        output o_output_pattern, o_freq_pattern, o_sel_out,
               o_start, o_stop, o_mode, o_done_tick, o_err_tick
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_decoder_byte_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : byte_shift_reg
// Brief    : DATA_BIT-wide loader; each load shifts right by one byte and
//            inserts the new byte at the top (LSB-first byte stream).
// Revision : 1.0 - initial release
// ============================================================================
module byte_shift_reg #(
    parameter int DATA_BIT = 32
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_load,
    input  wire logic [7:0]          i_byte,
    output logic      [DATA_BIT-1:0] o_q_next
);

    logic [DATA_BIT-1:0] r_q;
    logic [DATA_BIT-1:0] w_shifted;

    generate
        if (DATA_BIT > 8) begin : g_wide
            assign w_shifted = {i_byte, r_q[DATA_BIT-1:8]};
        end else begin : g_narrow
            assign w_shifted = i_byte;
        end
    endgenerate

    // Value the register holds after this edge, so a same-edge consumer
    // can capture a pattern including the byte being loaded right now.
    assign o_q_next = i_load ? w_shifted : r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= w_shifted;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder
// Brief    : Assembles PACK_NUM UART bytes into a command packet, validates
//            the channel select and publishes it with a done/err tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int DATA_BIT    = 32,
    parameter int PACK_NUM    = 9,
    parameter int NUM_CH      = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input wire logic          clk,
    input wire logic          rst_n,
    uart_cmd_decoder_if.slave bus
);

    localparam int c_num_bytes = DATA_BIT / 8;
    localparam int c_bcnt_w    = $clog2(c_num_bytes) + 1;
    localparam int c_to_w      = $clog2(TIMEOUT_CYC);
    localparam logic [c_bcnt_w-1:0] c_last_byte = c_bcnt_w'(c_num_bytes - 1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT_CYC - 1);

    generate
        if (!params_legal(DATA_BIT, PACK_NUM, NUM_CH, TIMEOUT_CYC)) begin : g_bad_params
            $error("uart_cmd_decoder: illegal DATA_BIT/PACK_NUM/NUM_CH/TIMEOUT_CYC");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_next;
    logic [c_bcnt_w-1:0]   r_byte_cnt;
    logic [c_bcnt_w-1:0]   w_byte_cnt_next;
    logic [c_to_w-1:0]     r_to_cnt;
    logic [c_to_w-1:0]     w_to_cnt_next;

    logic [3:0]            r_sel;
    logic                  r_start;
    logic                  r_stop;
    logic                  r_mode;

    logic                  w_cmd_load;
    logic                  w_out_load;
    logic                  w_freq_load;
    logic                  w_commit;
    logic                  w_reject;
    logic                  w_timeout;
    logic                  w_sel_valid;

    logic [DATA_BIT-1:0]   w_out_next;
    logic [DATA_BIT-1:0]   w_freq_next;

    logic [DATA_BIT-1:0]   r_out_pat;
    logic [DATA_BIT-1:0]   r_freq_pat;
    logic [3:0]            r_sel_out;
    logic                  r_start_out;
    logic                  r_stop_out;
    logic                  r_mode_out;
    logic                  r_done_tick;
    logic                  r_err_tick;

    assign w_sel_valid = (32'(r_sel) < 32'(NUM_CH));

    byte_shift_reg #(.DATA_BIT(DATA_BIT)) u_out_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_out_load),
        .i_byte   (bus.i_data),
        .o_q_next (w_out_next)
    );

    byte_shift_reg #(.DATA_BIT(DATA_BIT)) u_freq_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_freq_load),
        .i_byte   (bus.i_data),
        .o_q_next (w_freq_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_to_cnt   <= w_to_cnt_next;
        end
    end

    // Timeout counter defaults to 0, which also covers IDLE/DONE and the
    // "tick on the expiry cycle wins" rule in the pattern states.
    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_to_cnt_next   = '0;
        w_cmd_load      = 1'b0;
        w_out_load      = 1'b0;
        w_freq_load     = 1'b0;
        w_commit        = 1'b0;
        w_reject        = 1'b0;
        w_timeout       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_rx_done_tick) begin
                    w_cmd_load      = 1'b1;
                    w_byte_cnt_next = '0;
                    w_state_next    = S_OUT;
                end
            end
            S_OUT, S_FREQ: begin
                if (bus.i_rx_done_tick) begin
                    w_out_load  = (r_state == S_OUT);
                    w_freq_load = (r_state == S_FREQ);
                    if (r_byte_cnt == c_last_byte) begin
                        w_byte_cnt_next = '0;
                        if (r_state == S_OUT) begin
                            w_state_next = S_FREQ;
                        end else begin
                            w_state_next = S_DONE;
                            w_commit     = w_sel_valid;
                            w_reject     = !w_sel_valid;
                        end
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + 1'b1;
                    end
                end else if (r_to_cnt == c_to_last) begin
                    w_timeout       = 1'b1;
                    w_byte_cnt_next = '0;
                    w_state_next    = S_IDLE;
                end else begin
                    w_to_cnt_next = r_to_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_mode  <= MODE_ONESHOT;
        end else if (w_cmd_load) begin
            r_sel   <= bus.i_data[CMD_SEL_MSB:CMD_SEL_LSB];
            r_start <= bus.i_data[CMD_START_BIT];
            r_stop  <= bus.i_data[CMD_STOP_BIT];
            r_mode  <= bus.i_data[CMD_MODE_BIT];
        end
    end

    // Outputs are captured on the edge that accepts the final byte, so the
    // done tick and the new fields appear together in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_pat   <= '0;
            r_freq_pat  <= '0;
            r_sel_out   <= '0;
            r_start_out <= 1'b0;
            r_stop_out  <= 1'b0;
            r_mode_out  <= MODE_ONESHOT;
            r_done_tick <= 1'b0;
            r_err_tick  <= 1'b0;
        end else begin
            r_done_tick <= w_commit;
            r_err_tick  <= w_reject | w_timeout;
            if (w_commit) begin
                r_out_pat   <= w_out_next;
                r_freq_pat  <= w_freq_next;
                r_sel_out   <= r_sel;
                r_start_out <= r_start;
                r_stop_out  <= r_stop;
                r_mode_out  <= r_mode;
            end
        end
    end

    assign bus.o_output_pattern = r_out_pat;
    assign bus.o_freq_pattern   = r_freq_pat;
    assign bus.o_sel_out        = r_sel_out;
    assign bus.o_start          = r_start_out;
    assign bus.o_stop           = r_stop_out;
    assign bus.o_mode           = r_mode_out;
    assign bus.o_done_tick      = r_done_tick;
    assign bus.o_err_tick       = r_err_tick;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_decoder
// Brief    : Scoreboard bench for uart_cmd_decoder with a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

    localparam int DB  = 32;
    localparam int NB  = DB / 8;
    localparam int PN  = 1 + 2 * NB;
    localparam int NCH = 3;
    localparam int TO  = 50;

    typedef logic [7:0] pkt_t [PN];

    typedef struct {
        bit            is_err;
        longint        cyc;
        logic [DB-1:0] outp;
        logic [DB-1:0] freq;
        logic [6:0]    fields;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    longint cyc = 0;
    longint last_edge = 0;
    int     n_checks = 0;
    int     n_pass = 0;

    exp_t          sb[$];
    logic [DB-1:0] cur_out = '0;
    logic [DB-1:0] cur_freq = '0;
    logic [6:0]    cur_fields = '0;

    uart_cmd_decoder_if #(.DATA_BIT(DB)) bus ();

    uart_cmd_decoder #(
        .DATA_BIT    (DB),
        .PACK_NUM    (PN),
        .NUM_CH      (NCH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Packet-level reference: fields come straight from the byte layout.
    function automatic exp_t model(input pkt_t b, input longint at);
        exp_t e;
        int   sel, start, stop, mode;
        sel   = int'(b[0]) % 16;
        start = int'(b[0]) / 128;
        stop  = (int'(b[0]) / 64) % 2;
        mode  = (int'(b[0]) / 32) % 2;
        e.is_err = (sel >= NCH);
        e.cyc    = at;
        e.outp   = '0;
        e.freq   = '0;
        for (int i = 0; i < NB; i++) begin
            e.outp = e.outp | (DB'(b[1+i]) << (8*i));
            e.freq = e.freq | (DB'(b[1+NB+i]) << (8*i));
        end
        e.fields = 7'(sel*8 + start*4 + stop*2 + mode);
        return e;
    endfunction

    // Monitor: pops on each event and also checks output stability every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.o_done_tick && bus.o_err_tick) chk("done_err_overlap", 64'd1, 64'd0);
            if (sb.size() > 0 && sb[0].cyc < cyc && !(bus.o_done_tick || bus.o_err_tick)) begin
                e = sb.pop_front();
                chk("missing_event", 64'(cyc), 64'(e.cyc));
            end
            if (bus.o_done_tick || bus.o_err_tick) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {62'd0, bus.o_done_tick, bus.o_err_tick}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("event_is_err", 64'(bus.o_err_tick), 64'(e.is_err));
                    chk("event_cycle", 64'(cyc), 64'(e.cyc));
                    if (!e.is_err) begin
                        cur_out    = e.outp;
                        cur_freq   = e.freq;
                        cur_fields = e.fields;
                    end
                end
            end
        end
        chk("out_pattern", 64'(bus.o_output_pattern), 64'(cur_out));
        chk("freq_and_cmd", {25'd0, bus.o_sel_out, bus.o_start, bus.o_stop, bus.o_mode, bus.o_freq_pattern},
                            {25'd0, cur_fields, cur_freq});
    end

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        bus.i_data         = b;
        bus.i_rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        last_edge          = cyc;
        bus.i_rx_done_tick = 1'b0;
        bus.i_data         = 8'($urandom);
    endtask

    // Sends the first n bytes of b; a short packet is expected to time out.
    task automatic send(input pkt_t b, input int n, input int gmin, input int gmax,
                        input int long_at, input int long_gap);
        exp_t e;
        int   g;
        idle(1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                g = (i == long_at) ? long_gap : int'($urandom_range(gmax, gmin));
                idle(g - 1);
            end
            put_byte(b[i]);
        end
        if (n == PN) begin
            sb.push_back(model(b, last_edge));
        end else begin
            e = '{default: '0};
            e.is_err = 1'b1;
            e.cyc    = last_edge + TO;
            sb.push_back(e);
            idle(TO + 3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        pkt_t p;
        int   n, la;
        rst_n              = 1'b0;
        bus.i_data         = 8'h00;
        bus.i_rx_done_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.o_output_pattern, bus.o_freq_pattern}, 64'd0);
        chk("reset_fields", {56'd0, bus.o_sel_out, bus.o_start, bus.o_stop, bus.o_mode, bus.o_done_tick}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Plain packet with fixed expected values.
        p = '{8'h81, 8'h78, 8'h56, 8'h34, 8'h12, 8'hF0, 8'h0F, 8'hF0, 8'h0F};
        send(p, PN, 1, 1, -1, 0);
        idle(3);
        chk("t1_out", 64'(bus.o_output_pattern), 64'h12345678);
        chk("t1_freq", 64'(bus.o_freq_pattern), 64'h0FF00FF0);
        chk("t1_cmd", {57'd0, bus.o_sel_out, bus.o_start, bus.o_stop, bus.o_mode}, {57'd0, 4'd1, 3'b100});

        p = '{8'hA2, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00};
        send(p, PN, 1, 3, -1, 0);
        idle(3);
        chk("t2_out", 64'(bus.o_output_pattern), 64'hAAAAAAAA);
        chk("t2_cmd", {57'd0, bus.o_sel_out, bus.o_start, bus.o_stop, bus.o_mode}, {57'd0, 4'd2, 3'b101});

        // Invalid select: error tick, outputs hold.
        p = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send(p, PN, 1, 2, -1, 0);
        idle(3);
        chk("t3_hold", 64'(bus.o_output_pattern), 64'hAAAAAAAA);

        // Stalled packet, then recovery.
        p = '{8'h82, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        send(p, 4, 1, 2, -1, 0);
        chk("t4_hold", 64'(bus.o_output_pattern), 64'hAAAAAAAA);
        send(p, PN, 1, 2, -1, 0);
        idle(3);
        chk("t4_recover", 64'(bus.o_output_pattern), 64'hEFBEADDE);

        // A byte arriving on the expiry cycle is still accepted.
        p = '{8'h20, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        send(p, PN, 1, 1, 5, TO);

        // Reset in the middle of a packet.
        idle(1);
        for (int i = 0; i < 6; i++) put_byte(p[i]);
        rst_n      = 1'b0;
        sb.delete();
        cur_out    = '0;
        cur_freq   = '0;
        cur_fields = '0;
        idle(2);
        chk("t5_reset_out", 64'(bus.o_output_pattern), 64'd0);
        rst_n = 1'b1;
        p = '{8'h40, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        send(p, PN, 1, 2, -1, 0);
        idle(3);
        chk("t5_cmd", {57'd0, bus.o_sel_out, bus.o_start, bus.o_stop, bus.o_mode}, {57'd0, 4'd0, 3'b010});

        // Back-to-back packets, one byte every 2 cycles.
        p = '{8'h80, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        send(p, PN, 2, 2, -1, 0);
        p = '{8'h81, 8'h33, 8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h44};
        send(p, PN, 2, 2, -1, 0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < PN; i++) p[i] = 8'($urandom);
            if ($urandom % 2 == 0) p[0][3:0] = 4'($urandom % NCH);
            n  = ($urandom % 6 == 0) ? int'($urandom_range(PN - 1, 1)) : PN;
            la = ($urandom % 8 == 0) ? int'($urandom_range(PN - 1, 1)) : -1;
            send(p, n, 1, 3, la, TO);
        end

        idle(10);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
